// File: rtl/regfile_mrw_pkg.sv
// Shared defaults, enable levels and address type for the multi-port register file.
package regfile_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int REG_NUM_DEF = 32;

  localparam logic [DATA_W_DEF-1:0] ZeroWord = '0;

  localparam logic WR_EN   = 1'b1;
  localparam logic RD_EN   = 1'b1;
  localparam logic RST_ACT = 1'b1;

  typedef logic [$clog2(REG_NUM_DEF)-1:0] addr_t;
endpackage

// File: rtl/regfile_mrw_if.sv
// Decode/writeback-facing bus of the register file; master drives, slave is the regfile.
interface regfile_mrw_if
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int NRD     = 2,
  parameter int NWR     = 2
);
  localparam int ADDR_W = $clog2(REG_NUM);

  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NRD-1:0]        re;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  iss_valid;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  flush;
  logic [ADDR_W:0]       busy_cnt;

  modport master (
    output we, waddr, wdata, re, raddr, iss_valid, iss_addr, flush,
    input  rdata, rbusy, busy_cnt
  );
  modport slave (
    input  we, waddr, wdata, re, raddr, iss_valid, iss_addr, flush,
    output rdata, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_mrw_scoreboard.sv
// Per-register pending bits: flush > issue set > writeback clear; busy_cnt tracks the popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int NWR     = 2,
  localparam int ADDR_W = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  flush,
  output logic [REG_NUM-1:0]    pend,
  output logic [ADDR_W:0]       busy_cnt
);
  logic [REG_NUM-1:0] pend_nxt;
  logic [ADDR_W:0]    cnt_nxt;

  always_comb begin
    pend_nxt = pend;
    if (flush) begin
      pend_nxt = '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (we[k] == WR_EN) pend_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
      // A new producer supersedes the one writing back this cycle.
      if (iss_valid) pend_nxt[iss_addr] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < REG_NUM; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/regfile_mrw.sv
// Multi-read/multi-write register file with same-cycle write bypass and pending scoreboard.
module regfile_mrw
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int NRD     = 2,
  parameter int NWR     = 2
) (
  input logic          clk,
  input logic          rst,
  regfile_mrw_if.slave bus
);
  localparam int ADDR_W = $clog2(REG_NUM);

  logic [REG_NUM-1:0][DATA_W-1:0] mem;
  logic [REG_NUM-1:0]             pend;
  logic [NRD*DATA_W-1:0]          rdata_v;
  logic [NRD-1:0]                 rbusy_v;
  logic [ADDR_W-1:0]              ra;
  logic [DATA_W-1:0]              rd;
  logic                           hit;

  // Later ports overwrite earlier ones in the loop, so the younger port wins.
  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      mem <= '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (bus.we[k] == WR_EN && bus.waddr[k*ADDR_W +: ADDR_W] != '0)
          mem[bus.waddr[k*ADDR_W +: ADDR_W]] <= bus.wdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rdata_v = '0;
    rbusy_v = '0;
    ra      = '0;
    rd      = '0;
    hit     = 1'b0;
    for (int r = 0; r < NRD; r++) begin
      ra  = bus.raddr[r*ADDR_W +: ADDR_W];
      rd  = mem[ra];
      hit = 1'b0;
      for (int k = 0; k < NWR; k++)
        if (bus.we[k] == WR_EN && bus.waddr[k*ADDR_W +: ADDR_W] == ra) begin
          rd  = bus.wdata[k*DATA_W +: DATA_W];
          hit = 1'b1;
        end
      if (rst != RST_ACT && bus.re[r] == RD_EN && ra != '0) begin
        rdata_v[r*DATA_W +: DATA_W] = rd;
        rbusy_v[r]                  = pend[ra] & ~hit;
      end
    end
  end

  assign bus.rdata = rdata_v;
  assign bus.rbusy = rbusy_v;

  regfile_scoreboard #(.REG_NUM(REG_NUM), .NWR(NWR)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (bus.we),
    .waddr    (bus.waddr),
    .iss_valid(bus.iss_valid),
    .iss_addr (bus.iss_addr),
    .flush    (bus.flush),
    .pend     (pend),
    .busy_cnt (bus.busy_cnt)
  );
endmodule
